mdr_load_unit: RTL and testbench
================================

Name: mdr_load_unit

Overview:
Registered successor to the combinational memory data register, parametrised in bus width and memory latency.
- Issues a load, waits a fixed number of memory wait cycles, then captures memory data.
- Extracts the addressed byte/half/word/double lane, sign- or zero-extends it, and presents raw and extended values to the writeback muxes.
- Sits between data memory read port and the MemtoReg datapath mux.
- Flags misaligned or illegal loads instead of capturing.

Parameters:
DATA_W, 32, memory/datapath width; legal values 32 or 64.
MEM_LATENCY, 1, memory read wait cycles; legal range 1..15.
OFS_W, $clog2(DATA_W/8), byte-offset width (derived; not overridden).

Ports:
clk  in  1  single clock; all state on rising edge.
reset  in  1  asynchronous, active-high; returns block to IDLE.
load_req  in  1  start load; sampled only in IDLE.
load_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
load_signed  in  1  1 sign-extend, 0 zero-extend.
addr_lo  in  OFS_W  byte offset within the memory word.
mem_data  in  DATA_W  memory read data; must be stable at the capture edge.
mdr_raw  out  DATA_W  unmodified captured memory word.
mdr_ext  out  DATA_W  selected lane, extended to DATA_W.
busy  out  1  high while waiting on memory.
valid  out  1  one-cycle pulse: mdr_raw/mdr_ext updated.
misaligned  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, mdr_raw=0, mdr_ext=0, busy=0, valid=0, misaligned=0. Reset mid-WAIT abandons the load; no valid is issued.
- FSM states IDLE and WAIT; 4-bit counter cnt.
- IDLE with load_req=1 and a legal request:
  - latch size, signed and addr_lo;
  - cnt<=MEM_LATENCY-1; go to WAIT; busy=1 from the next cycle.
- Legality rules:
  - half needs addr_lo[0]=0; word needs addr_lo[1:0]=0; double needs addr_lo=0.
  - size 11 with DATA_W=32 is illegal.
- Illegal request: stay IDLE; misaligned=1 for exactly one cycle; mdr_raw and mdr_ext unchanged; no memory wait.
- WAIT with cnt!=0: cnt decrements.
- WAIT with cnt==0, at that edge:
  - mdr_raw<=mem_data; mdr_ext<=extended lane; valid<=1;
  - busy<=0; go to IDLE.
- Latency: request sampled at edge E0; mem_data sampled at edge E0+MEM_LATENCY; valid high for the cycle following that edge.
- load_req while in WAIT: ignored; no queueing.
- load_req in the cycle valid is high: accepted, since state is IDLE. This gives back-to-back throughput of one load per MEM_LATENCY+1 cycles.
- Lane selection (little-endian default):
  - byte = mem_data[8*addr_lo +: 8]; half = mem_data[8*addr_lo +: 16]; word = mem_data[8*addr_lo +: 32]; double = full word.
- Extension: lane MSB replicated when signed=1, else zeros. Double ignores signed.
- valid and misaligned are never high together; both are registered outputs.

Optional Feature:
Macro MDR_BIG_ENDIAN_EN.
- Defined: lanes are mirrored. Byte at offset k = mem_data[DATA_W-1-8k -: 8]; half/word select from the MSB end likewise.
- Undefined: little-endian mapping above.
- Legality, timing and all other behaviour are identical either way.

Decomposition:
- Shared package mdr_pkg:
  - load_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE);
  - mdr_state_t (IDLE, WAIT);
  - localparam CNT_W=4.
- One natural sub-module: mdr_lane_extract. It is purely combinational, takes (data, size, signed, ofs) and returns the extended value. The endian macro is applied inside it; it is reused by the store-path byte-enable logic.

Test Plan:
1. DATA_W=32, MEM_LATENCY=1: byte, signed, addr_lo=2, mem_data=0x12_80_34_56 -> valid 2 cycles after request; mdr_ext=0xFFFFFF80; mdr_raw=0x12803456.
2. Half, unsigned, addr_lo=2, mem_data=0x8001_7FFF -> mdr_ext=0x00008001. Same request with signed -> 0xFFFF8001.
3. Word with addr_lo=1 -> misaligned pulse next cycle; busy stays 0; mdr_raw keeps its previous value; no valid.
4. MEM_LATENCY=3: load_req held high during WAIT -> exactly one valid per 4 cycles; second load uses parameters latched when it was accepted.
5. Reset asserted asynchronously mid-WAIT -> busy, valid and outputs go to 0 immediately; no valid after release until a new request.
6. DATA_W=64, double, mem_data=0xDEADBEEF_01234567 -> mdr_ext equals mem_data. With MDR_BIG_ENDIAN_EN, byte at addr_lo=0 -> 0x000000DE (unsigned).

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types for the memory data register load path: load sizes, FSM states
// and the request legality rule.
package mdr_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'b00,
      SZ_HALF   = 2'b01,
      SZ_WORD   = 2'b10,
      SZ_DOUBLE = 2'b11
   } load_size_t;

   typedef logic [0:0] mdr_state_t;
   localparam mdr_state_t IDLE = 1'b0;
   localparam mdr_state_t WAIT = 1'b1;

   // Natural alignment; double only exists on a 64-bit bus.
   function automatic logic req_legal(input load_size_t size, input logic [2:0] ofs,
                                      input int data_w);
      case (size)
         SZ_BYTE:   return 1'b1;
         SZ_HALF:   return ofs[0] == 1'b0;
         SZ_WORD:   return ofs[1:0] == 2'b00;
         SZ_DOUBLE: return (data_w == 64) && (ofs == 3'd0);
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdr_lane_extract.sv
// Combinational lane select + sign/zero extend. Define MDR_BIG_ENDIAN_EN to
// mirror the byte offset so offset 0 addresses the most significant byte.
module mdr_lane_extract
   import mdr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFS_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data,
   input  load_size_t        size,
   input  logic              sgn,
   input  logic [OFS_W-1:0]  ofs,
   output logic [DATA_W-1:0] ext
);

   logic [OFS_W+2:0]  shamt;
   logic [DATA_W-1:0] aligned;
   logic [DATA_W-1:0] mask;
   logic              msb;

   assign shamt = {ofs, 3'b000};

`ifdef MDR_BIG_ENDIAN_EN
   // Push the addressed lane to the top, then drop it to the bottom.
   logic [DATA_W-1:0] mirrored;
   assign mirrored = data << shamt;

   always_comb begin
      aligned = data;
      case (size)
         SZ_BYTE: aligned = mirrored >> (DATA_W-8);
         SZ_HALF: aligned = mirrored >> (DATA_W-16);
         SZ_WORD: aligned = mirrored >> (DATA_W-32);
         default: aligned = data;
      endcase
   end
`else
   assign aligned = data >> shamt;
`endif

   always_comb begin
      mask = '1;
      msb  = 1'b0;
      case (size)
         SZ_BYTE: begin mask = ~({DATA_W{1'b1}} << 8);  msb = aligned[7];  end
         SZ_HALF: begin mask = ~({DATA_W{1'b1}} << 16); msb = aligned[15]; end
         SZ_WORD: begin mask = ~({DATA_W{1'b1}} << 32); msb = aligned[31]; end
         default: begin mask = '1;                      msb = 1'b0;        end
      endcase
      ext = (aligned & mask) | ({DATA_W{sgn & msb}} & ~mask);
   end

endmodule

// File: rtl/mdr_load_unit.sv
// Registered memory data register: issue, fixed memory wait, capture and
// extend. Endianness of lane selection follows MDR_BIG_ENDIAN_EN.
module mdr_load_unit
   import mdr_pkg::*;
#(
   parameter  int DATA_W      = 32,
   parameter  int MEM_LATENCY = 1,
   localparam int OFS_W       = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic [1:0]        load_size,
   input  logic              load_signed,
   input  logic [OFS_W-1:0]  addr_lo,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] mdr_raw,
   output logic [DATA_W-1:0] mdr_ext,
   output logic              busy,
   output logic              valid,
   output logic              misaligned
);

   mdr_state_t        state;
   logic [CNT_W-1:0]  cnt;
   load_size_t        size_q;
   logic              sgn_q;
   logic [OFS_W-1:0]  ofs_q;
   logic [DATA_W-1:0] ext_d;
   logic              legal;

   assign legal = req_legal(load_size_t'(load_size), 3'(addr_lo), DATA_W);

   // Extraction runs on the latched request so inputs may change mid-wait.
   mdr_lane_extract #(.DATA_W(DATA_W), .OFS_W(OFS_W)) u_extract (
      .data (mem_data),
      .size (size_q),
      .sgn  (sgn_q),
      .ofs  (ofs_q),
      .ext  (ext_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         size_q     <= SZ_BYTE;
         sgn_q      <= 1'b0;
         ofs_q      <= '0;
         mdr_raw    <= '0;
         mdr_ext    <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         valid      <= 1'b0;
         misaligned <= 1'b0;
         case (state)
            IDLE: begin
               if (load_req) begin
                  if (legal) begin
                     size_q <= load_size_t'(load_size);
                     sgn_q  <= load_signed;
                     ofs_q  <= addr_lo;
                     cnt    <= CNT_W'(MEM_LATENCY-1);
                     busy   <= 1'b1;
                     state  <= WAIT;
                  end else begin
                     misaligned <= 1'b1;
                  end
               end
            end
            default: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  mdr_raw <= mem_data;
                  mdr_ext <= ext_d;
                  valid   <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdr_load_unit.sv
// Bench for mdr_load_unit: a 32-bit/latency-1 unit and a 64-bit/latency-3 unit
// checked against a byte-list reference model.
module tb_mdr_load_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_req, a_sgn, a_busy, a_valid, a_mis;
   logic [1:0]  a_size, a_ofs;
   logic [31:0] a_data, a_raw, a_ext;
   logic        b_req, b_sgn, b_busy, b_valid, b_mis;
   logic [1:0]  b_size;
   logic [2:0]  b_ofs;
   logic [63:0] b_data, b_raw, b_ext;

   mdr_load_unit #(.DATA_W(32), .MEM_LATENCY(1)) u32 (
      .clk(clk), .reset(reset), .load_req(a_req), .load_size(a_size),
      .load_signed(a_sgn), .addr_lo(a_ofs), .mem_data(a_data),
      .mdr_raw(a_raw), .mdr_ext(a_ext), .busy(a_busy), .valid(a_valid),
      .misaligned(a_mis));

   mdr_load_unit #(.DATA_W(64), .MEM_LATENCY(3)) u64 (
      .clk(clk), .reset(reset), .load_req(b_req), .load_size(b_size),
      .load_signed(b_sgn), .addr_lo(b_ofs), .mem_data(b_data),
      .mdr_raw(b_raw), .mdr_ext(b_ext), .busy(b_busy), .valid(b_valid),
      .misaligned(b_mis));

   logic [63:0] raw_v[2], ext_v[2];
   logic        busy_v[2], valid_v[2], mis_v[2];
   assign raw_v[0] = {32'h0, a_raw};  assign raw_v[1] = b_raw;
   assign ext_v[0] = {32'h0, a_ext};  assign ext_v[1] = b_ext;
   assign busy_v[0] = a_busy;   assign busy_v[1] = b_busy;
   assign valid_v[0] = a_valid; assign valid_v[1] = b_valid;
   assign mis_v[0] = a_mis;     assign mis_v[1] = b_mis;

   int tests = 0;
   int fails = 0;
   logic [63:0] sh_raw[2], sh_ext[2];

`ifdef MDR_BIG_ENDIAN_EN
   localparam logic [63:0] E0 = 64'h34, E1 = 64'h7FFF, E2 = 64'h7FFF;
   localparam logic [63:0] E5 = 64'hDE, E6 = 64'h7FFF_FFFF, E7 = 64'h1234;
`else
   localparam logic [63:0] E0 = 64'hFFFF_FF80, E1 = 64'h8001, E2 = 64'hFFFF_8001;
   localparam logic [63:0] E5 = 64'h67, E6 = 64'hFFFF_FFFF_8000_0000;
   localparam logic [63:0] E7 = 64'hFFFF_FFFF_FFFF_FFEE;
`endif

   typedef struct {
      int          u;
      logic [1:0]  sz;
      bit          sg;
      logic [2:0]  ofs;
      logic [63:0] data;
      bit          legal;
      logic [63:0] ext;
      string       nm;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: gather lane bytes by address, assemble, extend.
   function automatic logic [63:0] ref_ext(input int dw, input logic [63:0] d, input int sz,
                                           input bit sg, input int ofs);
      int n;
      logic [63:0] v;
      logic [7:0] b;
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++) begin
`ifdef MDR_BIG_ENDIAN_EN
         b = d[(dw-1-8*(ofs+i)) -: 8];
         v = (v << 8) | 64'(b);
`else
         b = d[8*(ofs+i) +: 8];
         v = v | (64'(b) << (8*i));
`endif
      end
      if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      if (dw == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   function automatic bit ref_legal(input int dw, input int sz, input int ofs);
      int n;
      n = 1 << sz;
      if (n*8 > dw) return 1'b0;
      return (ofs % n) == 0;
   endfunction

   task automatic set_in(input int u, input logic rq, input logic [1:0] sz, input logic sg,
                         input logic [2:0] ofs, input logic [63:0] d);
      if (u == 0) begin
         a_req = rq; a_size = sz; a_sgn = sg; a_ofs = ofs[1:0]; a_data = d[31:0];
      end else begin
         b_req = rq; b_size = sz; b_sgn = sg; b_ofs = ofs; b_data = d;
      end
   endtask

   task automatic do_load(input int u, input logic [1:0] sz, input bit sg, input logic [2:0] ofs,
                          input logic [63:0] d, input bit legal, input logic [63:0] e,
                          input string nm);
      int lat, n;
      logic [63:0] dm;
      lat = (u == 0) ? 1 : 3;
      dm  = (u == 0) ? (d & 64'hFFFF_FFFF) : d;
      @(negedge clk); set_in(u, 1'b1, sz, sg, ofs, dm);
      @(negedge clk); set_in(u, 1'b0, sz, sg, ofs, dm);
      if (!legal) begin
         chk({nm, " mis"},   64'(mis_v[u]), 64'd1);
         chk({nm, " busy"},  64'(busy_v[u]), 64'd0);
         chk({nm, " valid"}, 64'(valid_v[u]), 64'd0);
         chk({nm, " raw"},   raw_v[u], sh_raw[u]);
         chk({nm, " ext"},   ext_v[u], sh_ext[u]);
         @(negedge clk);
         chk({nm, " mis1"},  64'(mis_v[u]), 64'd0);
         chk({nm, " val1"},  64'(valid_v[u]), 64'd0);
      end else begin
         chk({nm, " mis"},  64'(mis_v[u]), 64'd0);
         chk({nm, " busy"}, 64'(busy_v[u]), 64'd1);
         n = 0;
         while (!valid_v[u] && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk({nm, " lat"},   64'(n), 64'(lat));
         chk({nm, " valid"}, 64'(valid_v[u]), 64'd1);
         chk({nm, " raw"},   raw_v[u], dm);
         chk({nm, " ext"},   ext_v[u], e);
         chk({nm, " busy0"}, 64'(busy_v[u]), 64'd0);
         sh_raw[u] = dm;
         sh_ext[u] = e;
         @(negedge clk);
         chk({nm, " pulse"}, 64'(valid_v[u]), 64'd0);
      end
   endtask

   initial begin
      int nval, u, dw, sz, ofs;
      bit sg, idle_ok;
      logic [63:0] d, ea, eb;

      tbl[0]  = '{0, 2'd0, 1, 3'd2, 64'h1280_3456, 1, E0, "byte_s_o2"};
      tbl[1]  = '{0, 2'd1, 0, 3'd2, 64'h8001_7FFF, 1, E1, "half_u_o2"};
      tbl[2]  = '{0, 2'd1, 1, 3'd2, 64'h8001_7FFF, 1, E2, "half_s_o2"};
      tbl[3]  = '{0, 2'd2, 0, 3'd1, 64'h5555_AAAA, 0, 64'd0, "word_o1"};
      tbl[4]  = '{1, 2'd3, 1, 3'd0, 64'hDEAD_BEEF_0123_4567, 1, 64'hDEAD_BEEF_0123_4567, "dbl"};
      tbl[5]  = '{1, 2'd0, 0, 3'd0, 64'hDEAD_BEEF_0123_4567, 1, E5, "b64_u_o0"};
      tbl[6]  = '{1, 2'd2, 1, 3'd4, 64'h8000_0000_7FFF_FFFF, 1, E6, "w64_s_o4"};
      tbl[7]  = '{1, 2'd1, 1, 3'd6, 64'hFFEE_0000_0000_1234, 1, E7, "h64_s_o6"};
      tbl[8]  = '{0, 2'd3, 0, 3'd0, 64'h1111_2222, 0, 64'd0, "dbl_on32"};
      tbl[9]  = '{1, 2'd3, 0, 3'd4, 64'h1, 0, 64'd0, "dbl_o4"};
      tbl[10] = '{1, 2'd1, 0, 3'd3, 64'h2, 0, 64'd0, "half_o3"};

      reset = 1'b1;
      set_in(0, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0);
      set_in(1, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0);
      sh_raw[0] = '0; sh_raw[1] = '0; sh_ext[0] = '0; sh_ext[1] = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst raw",   raw_v[i], 64'd0);
         chk("rst ext",   ext_v[i], 64'd0);
         chk("rst busy",  64'(busy_v[i]), 64'd0);
         chk("rst valid", 64'(valid_v[i]), 64'd0);
         chk("rst mis",   64'(mis_v[i]), 64'd0);
      end
      reset = 1'b0;

      for (int i = 0; i < 11; i++)
         do_load(tbl[i].u, tbl[i].sz, tbl[i].sg, tbl[i].ofs, tbl[i].data,
                 tbl[i].legal, tbl[i].ext, tbl[i].nm);

      // load_req held through WAIT; the second load must use its own fields.
      d  = 64'hF1E2_D3C4_B5A6_9788;
      ea = ref_ext(64, d, 0, 1'b0, 1);
      eb = ref_ext(64, d, 1, 1'b1, 2);
      nval = 0;
      @(negedge clk); set_in(1, 1'b1, 2'd0, 1'b0, 3'd1, d);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (b_valid) begin
            nval++;
            chk("hold at", 64'(i), (nval == 1) ? 64'd3 : 64'd7);
            chk("hold ext", b_ext, (nval == 1) ? ea : eb);
         end
         if (i == 0) set_in(1, 1'b1, 2'd1, 1'b1, 3'd2, d);
         if (i == 4) set_in(1, 1'b0, 2'd1, 1'b1, 3'd2, d);
      end
      chk("hold count", 64'(nval), 64'd2);
      sh_raw[1] = d; sh_ext[1] = eb;

      // Asynchronous reset in the middle of a wait.
      @(negedge clk); set_in(1, 1'b1, 2'd2, 1'b0, 3'd0, d);
      @(negedge clk); set_in(1, 1'b0, 2'd2, 1'b0, 3'd0, d);
      chk("pre-rst busy", 64'(b_busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst busy",  64'(b_busy), 64'd0);
      chk("arst valid", 64'(b_valid), 64'd0);
      chk("arst raw",   b_raw, 64'd0);
      chk("arst ext",   b_ext, 64'd0);
      chk("arst raw32", 64'(a_raw), 64'd0);
      @(negedge clk); reset = 1'b0;
      sh_raw[0] = '0; sh_raw[1] = '0; sh_ext[0] = '0; sh_ext[1] = '0;
      idle_ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (b_valid || b_busy) idle_ok = 1'b0;
      end
      chk("post-rst idle", 64'(idle_ok), 64'd1);

      for (int i = 0; i < 120; i++) begin
         u   = int'($urandom_range(0, 1));
         dw  = (u == 0) ? 32 : 64;
         sz  = int'($urandom_range(0, 3));
         sg  = bit'($urandom_range(0, 1));
         ofs = int'($urandom_range(0, dw/8 - 1));
         if ($urandom_range(0, 3) != 0) ofs = ofs & ~((1 << sz) - 1);
         d   = {$urandom, $urandom};
         if (u == 0) d = d & 64'hFFFF_FFFF;
         if (ref_legal(dw, sz, ofs))
            do_load(u, 2'(sz), sg, 3'(ofs), d, 1'b1, ref_ext(dw, d, sz, sg, ofs), "rnd");
         else
            do_load(u, 2'(sz), sg, 3'(ofs), d, 1'b0, 64'd0, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
